// File: rtl/ascii_dec_parser_if.sv
// Character-in / word-out handshake bundle for the signed decimal ASCII parser.
interface ascii_dec_parser_if;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [31:0] value;
  logic        value_err;
  logic        value_valid;
  logic        value_ready;

  modport master (
    output char_in, char_valid, value_ready,
    input  char_ready, value, value_err, value_valid
  );

  modport slave (
    input  char_in, char_valid, value_ready,
    output char_ready, value, value_err, value_valid
  );
endinterface

// File: rtl/ascii_dec_parser.sv
// Streaming signed decimal ASCII to 32-bit two's-complement converter.
// One token ([+-]?digits terminated by CR/LF/space) yields one result word.
module ascii_dec_parser #(
  parameter int MAX_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  ascii_dec_parser_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {IDLE, SIGN, DIGITS, DISCARD, OUT} state_t;
  typedef struct packed {
    logic        err;
    logic [31:0] value;
  } res_t;

  state_t          state, state_n;
  logic [33:0]     acc, acc_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            neg, neg_n;
  res_t            res, res_n;
  res_t            eval_res;
  logic            is_digit, is_term, take, in_range;
  logic [3:0]      d;

  assign is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
  assign is_term  = (bus.char_in == 8'h0D) || (bus.char_in == 8'h0A) ||
                    (bus.char_in == 8'h20);
  assign d        = bus.char_in[3:0];
  assign take     = bus.char_valid && bus.char_ready;

  assign bus.char_ready  = (state != OUT);
  assign bus.value_valid = (state == OUT);
  assign bus.value       = res.value;
  assign bus.value_err   = res.err;

  // Negative side reaches one further than positive: -2^31 is representable.
  assign in_range = neg ? (acc <= 34'd2147483648) : (acc <= 34'd2147483647);

  always_comb begin
    eval_res = '{err: 1'b1, value: 32'd0};
    if (in_range) eval_res = '{err: 1'b0, value: neg ? (~acc[31:0] + 32'd1) : acc[31:0]};
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    neg_n   = neg;
    res_n   = res;
    case (state)
      IDLE: if (take && !is_term) begin
        if (bus.char_in == 8'h2B) begin
          state_n = SIGN;
          neg_n   = 1'b0;
        end else if (bus.char_in == 8'h2D) begin
          state_n = SIGN;
          neg_n   = 1'b1;
        end else if (is_digit) begin
          state_n = DIGITS;
          acc_n   = {30'd0, d};
          cnt_n   = CW'(1);
          neg_n   = 1'b0;
        end else begin
          state_n = DISCARD;
        end
      end
      SIGN: if (take) begin
        if (is_digit) begin
          state_n = DIGITS;
          acc_n   = {30'd0, d};
          cnt_n   = CW'(1);
        end else if (is_term) begin
          state_n = OUT;
          res_n   = '{err: 1'b1, value: 32'd0};
          acc_n   = '0;
          cnt_n   = '0;
          neg_n   = 1'b0;
        end else begin
          state_n = DISCARD;
        end
      end
      DIGITS: if (take) begin
        if (is_digit) begin
          if (cnt < CW'(MAX_DIGITS)) begin
            acc_n = acc * 34'd10 + {30'd0, d};
            cnt_n = cnt + CW'(1);
          end else begin
            state_n = DISCARD;
          end
        end else if (is_term) begin
          state_n = OUT;
          res_n   = eval_res;
          acc_n   = '0;
          cnt_n   = '0;
          neg_n   = 1'b0;
        end else begin
          state_n = DISCARD;
        end
      end
      DISCARD: if (take && is_term) begin
        state_n = OUT;
        res_n   = '{err: 1'b1, value: 32'd0};
        acc_n   = '0;
        cnt_n   = '0;
        neg_n   = 1'b0;
      end
      OUT: if (bus.value_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      neg   <= neg_n;
      res   <= res_n;
    end
  end
endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Streaming decoder that converts signed decimal ASCII text into 32-bit two's-complement words. It is the inverse of the register-display path, which encodes a word as a sign character plus 10 decimal digits for the VGA text buffer. The parser accepts exactly that format, and shorter forms, from a character source such as a UART or keyboard front end. It sits between that source and the debug console's register-write logic.

## Interface
- MAX_DIGITS, 10, maximum decimal digits per token. Must stay ≤10 to keep the accumulator width valid.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  parser can accept a character. A character is consumed on char_valid && char_ready.
- value  out  32  parsed two's-complement result, registered.
- value_err  out  1  result is malformed or out of range. When set, value = 0.
- value_valid  out  1  value/value_err are valid.
- value_ready  in  1  consumer takes the result on value_valid && value_ready.

## Operation
- Token grammar: optional sign, then 1..MAX_DIGITS digits, then a terminator.
  - Sign is '+' 0x2B or '-' 0x2D.
  - Digits are '0'..'9', 0x30..0x39.
  - Terminators are CR 0x0D, LF 0x0A, or space 0x20.
- Leading zeros count as digits.
- State machine:
  - IDLE: ready=1.
    - Terminator → stay in IDLE; the character is skipped and no result is produced.
    - '+' → SIGN, neg=0.
    - '-' → SIGN, neg=1.
    - Digit → DIGITS, acc=d, cnt=1, neg=0.
    - Any other character → DISCARD.
  - SIGN: ready=1.
    - Digit → DIGITS, acc=d, cnt=1.
    - Terminator → OUT with error.
    - Anything else → DISCARD.
  - DIGITS: ready=1.
    - Digit with cnt<MAX_DIGITS → acc=acc*10+d, cnt+1.
    - Digit with cnt=MAX_DIGITS → DISCARD.
    - Terminator → OUT, result evaluated.
    - Anything else → DISCARD.
  - DISCARD: ready=1. Consumes characters until a terminator, then → OUT with error.
  - OUT: ready=0, value_valid=1. On value_ready → IDLE.
- Arithmetic:
  - acc is 34 bits unsigned. 10^10−1 < 2^34, so acc never wraps.
  - Range check at the terminator:
    - neg=0 requires acc ≤ 2147483647.
    - neg=1 requires acc ≤ 2147483648.
    - Violation → value=0, value_err=1.
  - In range: value = neg ? (~acc[31:0]+1) : acc[31:0]; value_err=0.
  - "-0" yields 0 with value_err=0.
- When the result is captured into value/value_err, acc, cnt and neg clear.
- Only one result is outstanding at a time. No input is accepted while a result is pending.

## Timing
- Reset values:
  - state=IDLE, char_ready=1, value=0, value_err=0, value_valid=0.
  - acc=0, cnt=0, neg=0.
- Throughput is one character per cycle while char_ready=1.
- char_ready is a combinational decode of state: 1 in all states except OUT.
- Latency: if a terminator is accepted on edge N, value_valid=1 after edge N. It is visible in the cycle between edges N and N+1.
- value_valid and value/value_err hold stable until a value_ready handshake.
- If value_ready is already high when value_valid rises, the handshake completes on the next edge, state returns to IDLE, and char_ready=1 one cycle after the result appeared.
- Minimum token-to-token spacing is therefore one idle cycle after each result.
- value_ready while value_valid=0 is ignored.
- char_valid while char_ready=0: the character is not consumed. The source must hold it.
- Reset asserted mid-token or mid-OUT discards all partial state. The pending result is lost with no output.

## Test plan
1. "+0000000042" then CR, char_valid every cycle, value_ready=1 → value=0x0000002A, value_err=0, value_valid for exactly 1 cycle, 1 cycle after the CR is accepted.
2. "-2147483648" then space → value=0x80000000, err=0. "2147483648" then LF → value=0, err=1. "-0" then CR → value=0, err=0.
3. "12a3" then CR → value=0, err=1. "-" then CR → err=1. "12345678901" (11 digits) then CR → err=1. char_ready stays 1 until each terminator.
4. Backpressure: after "7" then CR, hold value_ready=0 for 5 cycles → value=7 held stable, char_ready=0, a char_valid pulse with '9' is not consumed. Raise value_ready → handshake completes, then '9' is accepted.
5. "123", then rst low for 2 cycles, then "7" then CR → single result value=7, err=0. No result for the "123".
6. Space, space, CR, LF, "5", LF → exactly one result, value=5, err=0. The leading terminators produce no output.
